i2s_mic_receiver: RTL and testbench

I2S master receiver for a single MEMS microphone (INMP441-class: 24-bit data in 32-bit slots, MSB first, one-bit delay after WS). It generates SCK and WS from the 25 MHz board clock, deserialises SD for one selected channel, and presents a signed PCM sample with a one-cycle valid strobe. It also registers an 8-bit magnitude, `level`, which sits directly upstream of the LED level meter and drives its `data_in`.

---
 rtl/i2s_mic_receiver.sv | 80 ++++++++
 tb/tb_i2s_mic_receiver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_mic_receiver.sv
// I2S master receiver for one MEMS microphone: generates SCK/WS, deserialises SD,
// and publishes a signed sample plus a saturated 8-bit magnitude once per frame.
module i2s_mic_receiver #(
  parameter int CLK_DIV      = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int CHANNEL      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    i2s_sck,
  output logic                    i2s_ws,
  input  logic                    i2s_sd,
  output logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    sample_valid,
  output logic [7:0]              level
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SW = SAMPLE_WIDTH;

  logic [DW-1:0] div;
  logic          sck;
  logic [5:0]    bit_cnt;
  logic [SW-1:0] shift;

  logic          tick;
  logic          rise_tick;
  logic          fall_tick;
  logic [4:0]    slot_bit;
  logic          capture;
  logic          publish;
  logic [SW-1:0] captured;
  logic [SW:0]   ext;
  logic [SW:0]   abs_v;
  logic [7:0]    level_next;

  assign tick      = (div == DW'(CLK_DIV - 1));
  assign rise_tick = tick && !sck;
  assign fall_tick = tick && sck;
  assign slot_bit  = bit_cnt[4:0];
  assign capture   = rise_tick && (slot_bit != 5'd0) && (slot_bit <= 5'(SW));
  assign publish   = rise_tick && (slot_bit == 5'(SW)) && (bit_cnt[5] == 1'(CHANNEL));
  assign captured  = {shift[SW-2:0], i2s_sd};

  // Magnitude at SW+1 bits so the most negative code does not wrap; it saturates to 8'hFF.
  always_comb begin
    ext        = {captured[SW-1], captured};
    abs_v      = ext[SW] ? (~ext + 1'b1) : ext;
    level_next = abs_v[SW-1] ? 8'hFF : 8'(abs_v >> (SW - 9));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div          <= '0;
      sck          <= 1'b0;
      bit_cnt      <= '0;
      shift        <= '0;
      sample       <= '0;
      level        <= '0;
      sample_valid <= 1'b0;
    end else begin
      div          <= tick ? '0 : div + 1'b1;
      sample_valid <= publish;
      if (tick)
        sck <= ~sck;
      if (fall_tick)
        bit_cnt <= bit_cnt + 1'b1;
      if (capture)
        shift <= captured;
      if (publish) begin
        sample <= captured;
        level  <= level_next;
      end
    end
  end

  assign i2s_sck = sck;
  assign i2s_ws  = bit_cnt[5];

endmodule

// File: tb/tb_i2s_mic_receiver.sv
// Scoreboard bench: a left and a right receiver share one mic model; expected
// samples are queued when frames are loaded and popped on each sample_valid.
module tb_i2s_mic_receiver;

  localparam int CLK_DIV = 2;
  localparam int SW      = 16;

  typedef struct {
    logic [SW-1:0] s;
    logic [7:0]    l;
    int            e;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sd  = 1'b0;
  logic          sck_l, ws_l, valid_l, sck_r, ws_r, valid_r;
  logic [SW-1:0] sample_l, sample_r;
  logic [7:0]    level_l, level_r;

  exp_t          ql[$];
  exp_t          qr[$];
  int            checks   = 0;
  int            failures = 0;
  int            edge_n   = -1;
  int            p        = 0;
  int            f        = 0;
  int            ws_err   = 0;
  int            sync_err = 0;
  logic          sck_prev = 1'b0;
  logic [23:0]   fl[0:7];
  logic [23:0]   fr[0:7];

  i2s_mic_receiver #(.CLK_DIV(CLK_DIV), .SAMPLE_WIDTH(SW), .CHANNEL(0)) dut_l (
    .clk(clk), .rst(rst), .i2s_sck(sck_l), .i2s_ws(ws_l), .i2s_sd(sd),
    .sample(sample_l), .sample_valid(valid_l), .level(level_l)
  );

  i2s_mic_receiver #(.CLK_DIV(CLK_DIV), .SAMPLE_WIDTH(SW), .CHANNEL(1)) dut_r (
    .clk(clk), .rst(rst), .i2s_sck(sck_r), .i2s_ws(ws_r), .i2s_sd(sd),
    .sample(sample_r), .sample_valid(valid_r), .level(level_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= rst ? -1 : edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, expv, edge_n);
    end
  endtask

  // Delay bit and padding are driven high so any leak into the sample shows up.
  function automatic logic mic_bit(input int pos, input int frame);
    int          s;
    int          fi;
    logic [23:0] w;
    s  = pos % 32;
    fi = (frame > 7) ? 7 : frame;
    w  = (pos >= 32) ? fr[fi] : fl[fi];
    if (s == 0) return 1'b1;
    if (s <= 24) return w[24 - s];
    return 1'b1;
  endfunction

  // Mic model: advances one slot bit after each SCK fall, drives SD shortly after.
  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      p  = 0;
      f  = 0;
      sd = ~sd;
    end else begin
      if (sck_prev && !sck_l) begin
        if (p == 63) begin
          p = 0;
          f = f + 1;
        end else begin
          p = p + 1;
        end
      end
      sd = mic_bit(p, f);
      if (ws_l !== p[5]) ws_err++;
    end
    if (sck_l !== sck_r || ws_l !== ws_r) sync_err++;
    sck_prev = sck_l;
  end

  always @(negedge clk) begin
    if (valid_l === 1'b1) begin
      chk("left_queue_nonempty", 32'(ql.size() != 0), 32'd1);
      if (ql.size() != 0) begin
        exp_t e;
        e = ql.pop_front();
        chk("left_sample", 32'(sample_l), 32'(e.s));
        chk("left_level", 32'(level_l), 32'(e.l));
        chk("left_edge", edge_n, e.e);
      end
    end
    if (valid_r === 1'b1) begin
      chk("right_queue_nonempty", 32'(qr.size() != 0), 32'd1);
      if (qr.size() != 0) begin
        exp_t e;
        e = qr.pop_front();
        chk("right_sample", 32'(sample_r), 32'(e.s));
        chk("right_level", 32'(level_r), 32'(e.l));
        chk("right_edge", edge_n, e.e);
      end
    end
  end

  task automatic push_frame(input int fi, input logic [15:0] ls, input logic [7:0] ll,
                            input logic [15:0] rs, input logic [7:0] rl);
    ql.push_back('{s: ls, l: ll, e: 33*CLK_DIV - 1 + fi*128*CLK_DIV});
    qr.push_back('{s: rs, l: rl, e: 97*CLK_DIV - 1 + fi*128*CLK_DIV});
  endtask

  initial begin
    int n;
    fl[0] = 24'h1234AB; fr[0] = 24'hFFFFFF;
    fl[1] = 24'hFF00AB; fr[1] = 24'h800000;
    fl[2] = 24'h800000; fr[2] = 24'h7FFF00;
    fl[3] = 24'h7FFFFF; fr[3] = 24'h000000;
    fl[4] = 24'h000000; fr[4] = 24'h1234AB;
    fl[5] = 24'h5A5A5A; fr[5] = 24'h5A5A5A;
    fl[6] = 24'h5A5A5A; fr[6] = 24'h5A5A5A;
    fl[7] = 24'h5A5A5A; fr[7] = 24'h5A5A5A;

    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_sck", 32'(sck_l), 32'd0);
    chk("reset_ws", 32'(ws_l), 32'd0);
    chk("reset_sample", 32'(sample_l), 32'd0);
    chk("reset_level", 32'(level_l), 32'd0);
    chk("reset_valid", 32'(valid_l | valid_r), 32'd0);

    push_frame(0, 16'h1234, 8'h24, 16'hFFFF, 8'h00);
    push_frame(1, 16'hFF00, 8'h02, 16'h8000, 8'hFF);
    push_frame(2, 16'h8000, 8'hFF, 16'h7FFF, 8'hFF);
    push_frame(3, 16'h7FFF, 8'hFF, 16'h0000, 8'h00);
    push_frame(4, 16'h0000, 8'h00, 16'h1234, 8'h24);
    rst = 1'b0;

    @(posedge clk);
    @(negedge clk);
    chk("sck_low_after_edge0", 32'(sck_l), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("sck_rise_after_clk_div", 32'(sck_l), 32'd1);

    // Reset in the left slot of frame 5 at slot bit 10; its sample must never appear.
    n = 0;
    while (!(f == 5 && p == 10) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("midframe_point_reached", 32'(n < 5000), 32'd1);
    chk("frames_0_4_drained", 32'(ql.size() + qr.size()), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    push_frame(0, 16'h1234, 8'h24, 16'hFFFF, 8'h00);
    rst = 1'b0;

    n = 0;
    while ((ql.size() + qr.size()) != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("post_reset_frame_published", 32'(ql.size() + qr.size()), 32'd0);
    repeat (40) @(negedge clk);

    chk("ws_framing", ws_err, 0);
    chk("left_right_clock_sync", sync_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
